// File: rtl/cp0_timer_int.sv
// rtl/cp0_timer_int.sv - CP0 Count/Compare timer, Cause.TI and interrupt request handshake
module cp0_timer_int #(
   parameter logic [7:0] CNT_ADDR = 8'b01001000,
   parameter logic [7:0] CMP_ADDR = 8'b01011000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_mtc0_we,
   input  logic [7:0]  i_c0_addr,
   input  logic [31:0] i_c0_wdata,
   output logic [31:0] o_c0_rdata,
   input  logic [7:0]  i_status_im,
   input  logic        i_status_exl,
   input  logic        i_status_ie,
   input  logic [1:0]  i_cause_ip_sw,
   input  logic [5:0]  i_ext_int_in,
   output logic        o_c0_cause_ti,
   output logic [7:0]  o_int_ip,
   output logic        o_int_req,
   input  logic        i_int_ack,
   input  logic        i_int_cancel
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ACKED = 2'd2
   } state_t;

   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_tick;
   logic        r_cause_ti;
   logic [7:0]  r_int_ip;
   logic        r_int_req;
   state_t      r_state;

   logic        w_cnt_wr;
   logic        w_cmp_wr;
   logic [31:0] w_count_next;
   logic        w_ti_match;
   logic        w_pending;

   assign w_cnt_wr     = i_mtc0_we && (i_c0_addr == CNT_ADDR);
   assign w_cmp_wr     = i_mtc0_we && (i_c0_addr == CMP_ADDR);
   assign w_count_next = r_count + 32'd1;

   // Match only fires on a real increment edge; a direct Count load never matches.
   assign w_ti_match   = r_tick && !w_cnt_wr && (w_count_next == r_compare);

   // Pending uses the registered IP vector against the live Status fields.
   assign w_pending    = (|(r_int_ip & i_status_im)) & i_status_ie & ~i_status_exl;

   // Count advances on every other cycle; a Count write reloads and realigns the phase.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= 32'd0;
         r_tick  <= 1'b0;
      end else if (w_cnt_wr) begin
         r_count <= i_c0_wdata;
         r_tick  <= 1'b0;
      end else begin
         if (r_tick) begin
            r_count <= w_count_next;
         end
         r_tick <= ~r_tick;
      end
   end

   // Compare register and sticky TI flag; a Compare write clears TI even on a match edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_compare  <= 32'd0;
         r_cause_ti <= 1'b0;
      end else if (w_cmp_wr) begin
         r_compare  <= i_c0_wdata;
         r_cause_ti <= 1'b0;
      end else if (w_ti_match) begin
         r_cause_ti <= 1'b1;
      end
   end

   // Register the pending-source vector; timer shares IP7 with external line 5.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_int_ip <= 8'd0;
      end else begin
         r_int_ip <= {i_ext_int_in[5] | r_cause_ti, i_ext_int_in[4:0], i_cause_ip_sw};
      end
   end

   // Request handshake: raise on pending, drop on ack or withdrawn source, rearm on exception or cancel.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_int_req <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pending) begin
                  r_state   <= ST_REQ;
                  r_int_req <= 1'b1;
               end
            end
            ST_REQ: begin
               if (i_int_ack) begin
                  r_state   <= ST_ACKED;
                  r_int_req <= 1'b0;
               end else if (!w_pending) begin
                  r_state   <= ST_IDLE;
                  r_int_req <= 1'b0;
               end
            end
            ST_ACKED: begin
               r_int_req <= 1'b0;
               if (i_status_exl || i_int_cancel) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_int_req <= 1'b0;
            end
         endcase
      end
   end

   // Read mux shows the stored register value, never the write in flight.
   always_comb begin
      o_c0_rdata = 32'd0;
      if (i_c0_addr == CNT_ADDR) begin
         o_c0_rdata = r_count;
      end else if (i_c0_addr == CMP_ADDR) begin
         o_c0_rdata = r_compare;
      end
   end

   assign o_c0_cause_ti = r_cause_ti;
   assign o_int_ip      = r_int_ip;
   assign o_int_req     = r_int_req;

endmodule

// File: tb/tb_cp0_timer_int.sv
// tb/tb_cp0_timer_int.sv - scoreboard bench for cp0_timer_int
module tb_cp0_timer_int;

   localparam logic [7:0] CNT = 8'b01001000;
   localparam logic [7:0] CMP = 8'b01011000;

   logic        clk;
   logic        reset;
   logic        mtc0_we;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  im;
   logic        exl;
   logic        ie;
   logic [1:0]  sw;
   logic [5:0]  ext;
   logic        ti;
   logic [7:0]  ip;
   logic        req;
   logic        ack;
   logic        cancel;

   cp0_timer_int dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_mtc0_we     (mtc0_we),
      .i_c0_addr     (addr),
      .i_c0_wdata    (wdata),
      .o_c0_rdata    (rdata),
      .i_status_im   (im),
      .i_status_exl  (exl),
      .i_status_ie   (ie),
      .i_cause_ip_sw (sw),
      .i_ext_int_in  (ext),
      .o_c0_cause_ti (ti),
      .o_int_ip      (ip),
      .o_int_req     (req),
      .i_int_ack     (ack),
      .i_int_cancel  (cancel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ti;
      logic [7:0]  ip;
      logic        req;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [31:0] m_count;
   logic [31:0] m_cmp;
   logic        m_tick;
   logic        m_ti;
   logic [7:0]  m_ip;
   logic        m_req;
   int          m_st;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic model_edge();
      logic        pend;
      logic        cnt_wr;
      logic        cmp_wr;
      logic        n_ti;
      logic [7:0]  n_ip;
      if (reset) begin
         m_count = 0; m_cmp = 0; m_tick = 0; m_ti = 0; m_ip = 0; m_req = 0; m_st = 0;
         return;
      end
      pend   = (|(m_ip & im)) & ie & ~exl;
      cnt_wr = mtc0_we && (addr == CNT);
      cmp_wr = mtc0_we && (addr == CMP);
      n_ti   = m_ti;
      if (m_tick && !cnt_wr && ((m_count + 32'd1) == m_cmp)) n_ti = 1'b1;
      if (cmp_wr) begin
         n_ti  = 1'b0;
         m_cmp = wdata;
      end
      n_ip = {ext[5] | m_ti, ext[4:0], sw};
      if (cnt_wr) begin
         m_count = wdata;
         m_tick  = 1'b0;
      end else begin
         if (m_tick) m_count = m_count + 32'd1;
         m_tick = ~m_tick;
      end
      case (m_st)
         0: if (pend) begin m_st = 1; m_req = 1'b1; end
         1: begin
            if (ack) begin m_st = 2; m_req = 1'b0; end
            else if (!pend) begin m_st = 0; m_req = 1'b0; end
         end
         default: begin
            m_req = 1'b0;
            if (exl || cancel) m_st = 0;
         end
      endcase
      m_ti = n_ti;
      m_ip = n_ip;
   endtask

   // one clock: predict, push, clock, pop and compare
   task automatic step();
      exp_t e;
      model_edge();
      e.ti  = m_ti;
      e.ip  = m_ip;
      e.req = m_req;
      e.rd  = (addr == CNT) ? m_count : (addr == CMP) ? m_cmp : 32'd0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("sb_ti", {31'd0, ti}, {31'd0, e.ti});
      check("sb_ip", {24'd0, ip}, {24'd0, e.ip});
      check("sb_req", {31'd0, req}, {31'd0, e.req});
      check("sb_rdata", rdata, e.rd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      mtc0_we = 1'b1; addr = a; wdata = d;
      step();
      mtc0_we = 1'b0; addr = CNT;
   endtask

   initial begin
      logic seen;
      int   k;
      reset = 1'b1; mtc0_we = 0; addr = CNT; wdata = 0;
      im = 0; exl = 0; ie = 0; sw = 0; ext = 0; ack = 0; cancel = 0;
      #1;
      idle(2);
      check("rst_ti", {31'd0, ti}, 32'd0);
      check("rst_req", {31'd0, req}, 32'd0);
      check("rst_cnt", rdata, 32'd0);
      reset = 1'b0;

      // free-running count
      step();
      check("cnt_e1", rdata, 32'd0);
      step();
      check("cnt_e2", rdata, 32'd1);
      idle(18);
      check("cnt_e20", rdata, 32'd10);
      check("cnt_e20_ti", {31'd0, ti}, 32'd0);

      // Compare=5 from count=0
      wr(CNT, 32'd0);
      wr(CMP, 32'd5);
      seen = 1'b0;
      for (k = 0; k < 20 && !seen; k++) begin
         step();
         seen = ti;
      end
      check("ti5_seen", {31'd0, seen}, 32'd1);
      check("ti5_cnt", rdata, 32'd5);
      wr(CMP, 32'd100);
      check("ti_clr", {31'd0, ti}, 32'd0);

      // wrap with a Compare write on the matching edge
      wr(CMP, 32'd0);
      wr(CNT, 32'hFFFF_FFFE);
      idle(3);
      check("wrap_pre", rdata, 32'hFFFF_FFFF);
      wr(CMP, 32'd0);
      check("wrap_cmpwin", {31'd0, ti}, 32'd0);

      // plain wrap sets TI
      wr(CNT, 32'hFFFF_FFFE);
      idle(3);
      check("wrap_ti_pre", {31'd0, ti}, 32'd0);
      step();
      check("wrap_cnt", rdata, 32'd0);
      check("wrap_ti", {31'd0, ti}, 32'd1);

      // timer interrupt request, ack, exception entry
      ie = 1'b1; im = 8'h80;
      seen = 1'b0;
      for (k = 0; k < 2 && !seen; k++) begin
         step();
         seen = req;
      end
      check("ti_req", {31'd0, seen}, 32'd1);
      ack = 1'b1; step(); ack = 1'b0;
      check("ack_drop", {31'd0, req}, 32'd0);
      exl = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("exl_noreq", {31'd0, req}, 32'd0);
      end
      exl = 1'b0;
      wr(CMP, 32'd100);
      im = 8'h00;
      idle(4);
      check("quiet", {31'd0, req}, 32'd0);

      // one-cycle external pulse, source withdrawn without ack
      im = 8'h04;
      ext = 6'b000001; step();
      check("pulse_ip", {31'd0, ip[2]}, 32'd1);
      ext = 6'b000000; step();
      check("pulse_ip_gone", {31'd0, ip[2]}, 32'd0);
      check("pulse_req", {31'd0, req}, 32'd1);
      step();
      check("pulse_drop", {31'd0, req}, 32'd0);

      // cancel while acked with source still active
      im = 8'h08; ext = 6'b000010;
      seen = 1'b0;
      for (k = 0; k < 3 && !seen; k++) begin
         step();
         seen = req;
      end
      check("ext1_req", {31'd0, seen}, 32'd1);
      ack = 1'b1; step(); ack = 1'b0;
      check("ext1_ack", {31'd0, req}, 32'd0);
      cancel = 1'b1; step(); cancel = 1'b0;
      check("cancel_idle", {31'd0, req}, 32'd0);
      step();
      check("cancel_rereq", {31'd0, req}, 32'd1);
      reset = 1'b1; step(); reset = 1'b0;
      check("rst_in_req", {31'd0, req}, 32'd0);
      check("rst_in_ip", {24'd0, ip}, 32'd0);
      ext = 6'b0; im = 8'h0;
      idle(2);

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         ext    = (($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0);
         sw     = 2'($urandom_range(0, 7) == 0 ? $urandom : 0);
         im     = 8'($urandom);
         ie     = ($urandom_range(0, 3) != 0);
         exl    = ($urandom_range(0, 7) == 0);
         ack    = ($urandom_range(0, 3) == 0);
         cancel = ($urandom_range(0, 5) == 0);
         mtc0_we = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 2))
            0: addr = CNT;
            1: addr = CMP;
            default: addr = 8'h60;
         endcase
         wdata = m_count + 32'($urandom_range(0, 6));
         step();
      end
      mtc0_we = 0; ack = 0; cancel = 0; exl = 0;
      idle(2);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cp0_timer_int.md
Name: cp0_timer_int

Overview:
Companion to the CP0 status/cause register block, on the opposite side of its interface. The CP0 block stores Status/Cause/EPC and consumes exceptions from writeback; this block produces the timer interrupt and the interrupt request that the CP0 block and pipeline consume. It owns the Count and Compare registers and generates Cause.TI. It evaluates pending interrupts against Status (IM, EXL, IE) and drives a registered interrupt request into the pipeline, with an acknowledge/cancel handshake.

Parameters:
CNT_ADDR, 8'b01001000, CP0 address of Count ({rd=9, sel=0})
CMP_ADDR, 8'b01011000, CP0 address of Compare ({rd=11, sel=0})

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
mtc0_we  in  1  CP0 write strobe from writeback
c0_addr  in  8  CP0 read/write address {rd, sel}
c0_wdata  in  32  CP0 write data
c0_rdata  out  32  Count/Compare read data; 0 for any other address
status_im  in  8  Status.IM from CP0 block
status_exl  in  1  Status.EXL
status_ie  in  1  Status.IE
cause_ip_sw  in  2  Cause.IP[1:0], software interrupt bits
ext_int_in  in  6  external hardware interrupt lines
c0_cause_ti  out  1  timer interrupt flag to CP0 Cause.TI
int_ip  out  8  registered pending vector {ext[5]|ti, ext[4:0], sw[1:0]}
int_req  out  1  interrupt request to decode stage
int_ack  in  1  pipeline has tagged an instruction with the interrupt
int_cancel  in  1  tagged instruction flushed before reaching writeback

Behaviour:
- Reset values: count=0, compare=0, tick=0, c0_cause_ti=0, int_ip=0, int_req=0, state=IDLE. c0_rdata is combinational.
- tick toggles every cycle. count increments by 1 (mod 2^32) in cycles where tick==1, so Count advances every 2 cycles. Wrap from 32'hFFFFFFFF to 0 is silent.
- mtc0 to CNT_ADDR: count<=c0_wdata and tick<=0. This takes priority over the increment.
- mtc0 to CMP_ADDR: compare<=c0_wdata and c0_cause_ti<=0.
- TI set: when tick==1 and count+1==compare (equality on the increment edge), c0_cause_ti<=1. The flag is sticky until a Compare write or reset.
  - A Compare write in the same cycle as a match wins: TI=0.
  - Loading Count directly with a value equal to Compare does not set TI.
  - With reset compare=0, TI first sets after the count wraps.
- c0_rdata: count if c0_addr==CNT_ADDR, compare if c0_addr==CMP_ADDR, else 0. Reads reflect the current register value, not the in-flight write.
- int_ip is registered each cycle: {ext_int_in[5]|c0_cause_ti, ext_int_in[4:0], cause_ip_sw}.
- pending = (|(int_ip & status_im)) & status_ie & ~status_exl.
- Request FSM, state update on posedge:
  - IDLE: pending -> REQ, and int_req<=1 the same edge, so there is 2 cycles of latency from an ext_int_in edge to int_req.
  - REQ: int_ack -> ACKED with int_req<=0. If !pending and !int_ack -> IDLE with int_req<=0 (source withdrawn, request dropped).
  - ACKED: int_req held 0. status_exl==1 -> IDLE (exception entered). int_cancel -> IDLE. If both occur, go to IDLE.
- int_ack while in IDLE or ACKED is ignored.
- int_req is never 1 while status_exl==1 at the time of evaluation.
- reset asserted mid-operation (any state) forces all state to reset values on that edge.

Test Plan:
- Reset, no writes: count reads 0 for first 2 cycles, then 1, 2, ...; after 20 cycles count=10, c0_cause_ti=0, int_req=0.
- mtc0 Compare=5 at count=0 -> TI rises on the edge where count becomes 5. mtc0 Compare=100 later -> TI=0 next cycle.
- mtc0 Count=32'hFFFFFFFE with Compare=0 -> count wraps to 0 after 4 cycles and TI=1 on that edge. A Compare write on the matching edge instead -> TI=0.
- status_ie=1, exl=0, im=8'h80, TI=1 -> int_req=1 within 2 cycles. int_ack -> int_req=0, state ACKED. status_exl=1 -> IDLE, with no re-request while exl=1.
- im=8'h04, ext_int_in[0] pulsed 1 cycle: int_ip[2]=1 for one cycle -> REQ. Source gone with no ack -> int_req drops, back to IDLE.
- In ACKED, assert int_cancel with exl=0 and the source still active -> IDLE, then int_req reasserts 1 cycle later. Reset during REQ -> int_req=0 on the next edge.
